// File: rtl/paddle_pkg.sv
// Shared types and arithmetic helpers for the paddle axis emulator.
//   paddle_mode_t : source-mode encoding seen on the mode input
//   src_state_t   : which source currently drives the axes
//   clamp_step    : limit a scaled mouse delta to +/-max_step
//   sat_add       : add a step to an accumulator, saturating to a w-bit signed range
package paddle_pkg;

    typedef enum logic [1:0] {
        PM_AUTO   = 2'd0,
        PM_JOY    = 2'd1,
        PM_MOUSE  = 2'd2,
        PM_SPRING = 2'd3
    } paddle_mode_t;

    typedef enum logic {
        SRC_JOY   = 1'b0,
        SRC_MOUSE = 1'b1
    } src_state_t;

    // Scaled deltas span -1024..1016, so 12 bits hold them; accumulators
    // are at most 12 bits wide, so 13 bits hold acc + step without overflow.
    localparam int STEP_W = 12;
    localparam int ACC_W  = 13;

    typedef logic signed [STEP_W-1:0] step_t;
    typedef logic signed [ACC_W-1:0]  acc_t;

    function automatic step_t clamp_step(input step_t delta, input int max_step);
        step_t lim;
        lim = step_t'(max_step);
        if (delta > lim)
            return lim;
        else if (delta < -lim)
            return -lim;
        else
            return delta;
    endfunction

    function automatic acc_t sat_add(input acc_t acc, input acc_t step, input int w);
        logic signed [ACC_W:0] sum;
        logic signed [ACC_W:0] hi;
        logic signed [ACC_W:0] lo;
        sum = {acc[ACC_W-1], acc} + {step[ACC_W-1], step};
        hi  = (ACC_W+1)'((1 <<< (w - 1)) - 1);
        lo  = ~hi;
        if (sum > hi)
            sum = hi;
        else if (sum < lo)
            sum = lo;
        return acc_t'(sum);
    endfunction

endpackage

// File: rtl/paddle_axis_emu_if.sv
// Bus bundle between hps_io / the core and paddle_axis_emu.
//   ps2_mouse : hps_io mouse word (strobe, signs, buttons, dx, dy)
//   joya      : analog stick, [7:0] X, [15:8] Y, signed
//   mode      : source mode, gain : delta left-shift
//   axis_x/y  : signed paddle values, mouse_btn, src_mouse, upd
// master = stimulus side (hps_io), slave = paddle_axis_emu.
interface paddle_axis_emu_if #(parameter int W = 8);

    logic [24:0]         ps2_mouse;
    logic [15:0]         joya;
    logic [1:0]          mode;
    logic [1:0]          gain;
    logic signed [W-1:0] axis_x;
    logic signed [W-1:0] axis_y;
    logic [2:0]          mouse_btn;
    logic                src_mouse;
    logic                upd;

    modport master (
        output ps2_mouse, joya, mode, gain,
        input  axis_x, axis_y, mouse_btn, src_mouse, upd
    );

    modport slave (
        input  ps2_mouse, joya, mode, gain,
        output axis_x, axis_y, mouse_btn, src_mouse, upd
    );

endinterface

// File: rtl/paddle_axis_accum.sv
// One mouse-driven paddle axis.
//   delta/sign : raw 8-bit magnitude byte and sign bit from the mouse word
//   gain       : left-shift applied after halving the 9-bit delta
//   add_en     : apply the clamped step with saturation
//   clear      : force the accumulator to 0 (highest priority)
//   spring_en  : move a nonzero accumulator one count toward 0
//   acc        : W-bit signed accumulator
module paddle_axis_accum
    import paddle_pkg::*;
#(
    parameter int W        = 8,
    parameter int MAX_STEP = 10
)
(
    input  logic                clk_sys,
    input  logic                reset,
    input  logic [7:0]          delta,
    input  logic                sign,
    input  logic [1:0]          gain,
    input  logic                add_en,
    input  logic                clear,
    input  logic                spring_en,
    output logic signed [W-1:0] acc
);

    logic signed [8:0]   d9;
    step_t               scaled;
    step_t               step;
    acc_t                sum;
    logic signed [W-1:0] acc_next;

    always_comb begin
        d9       = {sign, delta};
        scaled   = step_t'(d9 >>> 1) <<< gain;
        step     = clamp_step(scaled, MAX_STEP);
        sum      = sat_add(acc_t'(acc), acc_t'(step), W);
        acc_next = acc;
        if (clear)
            acc_next = '0;
        else if (add_en)
            acc_next = sum[W-1:0];
        else if (spring_en && (acc != '0))
            acc_next = acc[W-1] ? acc + W'(1) : acc - W'(1);
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset)
            acc <= '0;
        else
            acc <= acc_next;
    end

endmodule

// File: rtl/paddle_axis_emu.sv
// Analog paddle source merging the HPS analog stick and the PS/2 mouse.
//   clk_sys, reset : system clock, asynchronous active-high reset
//   bus (slave)    : ps2_mouse, joya, mode, gain in;
//                    axis_x, axis_y, mouse_btn, src_mouse, upd out
// Parameters: W axis width (4..12), MAX_STEP per-event step limit,
// SPRING_DIV idle cycles between spring-return steps (mode 3).
module paddle_axis_emu
    import paddle_pkg::*;
#(
    parameter int W          = 8,
    parameter int MAX_STEP   = 10,
    parameter int SPRING_DIV = 65536
)
(
    input  logic             clk_sys,
    input  logic             reset,
    paddle_axis_emu_if.slave bus
);

    localparam int CNT_W = (SPRING_DIV > 1) ? $clog2(SPRING_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPRING_DIV - 1);

    paddle_mode_t        mode;
    src_state_t          state;
    src_state_t          state_next;
    logic                armed;
    logic                old_stb;
    logic                mouse_evt;
    logic                joy_active;
    logic                acc_add;
    logic                acc_clear;
    logic                spring_en;
    logic [CNT_W-1:0]    spring_cnt;
    logic [2:0]          btn_q;
    logic signed [W-1:0] acc_x;
    logic signed [W-1:0] acc_y;
    logic signed [W-1:0] joy_x_map;
    logic signed [W-1:0] joy_y_map;
    logic signed [W-1:0] joy_x_q;
    logic signed [W-1:0] joy_y_q;
    logic signed [W-1:0] axis_x;
    logic signed [W-1:0] axis_y;
    logic signed [W-1:0] prev_x;
    logic signed [W-1:0] prev_y;
    logic                src_mouse;
    logic                prev_src;
    logic                upd_q;
    logic                ps2_unused;

    assign ps2_unused = ^{bus.ps2_mouse[7:6], bus.ps2_mouse[3]};

    assign mode       = paddle_mode_t'(bus.mode);
    assign joy_active = (bus.joya != '0);
    assign mouse_evt  = armed & (bus.ps2_mouse[24] != old_stb);

    // The first cycle after reset only captures the strobe level as baseline.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            armed   <= 1'b0;
            old_stb <= 1'b0;
        end else begin
            armed   <= 1'b1;
            old_stb <= bus.ps2_mouse[24];
        end
    end

    // Source selection: state register
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset)
            state <= SRC_JOY;
        else
            state <= state_next;
    end

    // Source selection: next state (joystick wins over a same-cycle event)
    always_comb begin
        state_next = state;
        case (mode)
            PM_AUTO: begin
                if (joy_active)
                    state_next = SRC_JOY;
                else if (mouse_evt)
                    state_next = SRC_MOUSE;
            end
            PM_JOY:              state_next = SRC_JOY;
            PM_MOUSE, PM_SPRING: state_next = SRC_MOUSE;
            default:             state_next = state;
        endcase
    end

    // Source selection: outputs and accumulator controls
    always_comb begin
        acc_add   = 1'b0;
        acc_clear = 1'b0;
        spring_en = 1'b0;
        case (mode)
            PM_AUTO: begin
                acc_clear = joy_active;
                acc_add   = mouse_evt & ~joy_active;
            end
            PM_MOUSE: acc_add = mouse_evt;
            PM_SPRING: begin
                acc_add   = mouse_evt;
                spring_en = ~mouse_evt & (spring_cnt == CNT_LAST);
            end
            default: ;
        endcase
    end

    assign src_mouse = (state == SRC_MOUSE);

    // Counter runs only in spring mode, so leaving mode 3 clears it.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset)
            spring_cnt <= '0;
        else if (mode != PM_SPRING || mouse_evt || spring_cnt == CNT_LAST)
            spring_cnt <= '0;
        else
            spring_cnt <= spring_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset)
            btn_q <= '0;
        else if (mode == PM_JOY || (mode == PM_AUTO && joy_active))
            btn_q <= '0;
        else if (acc_add)
            btn_q <= bus.ps2_mouse[2:0];
    end

    paddle_axis_accum #(.W(W), .MAX_STEP(MAX_STEP)) u_acc_x (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .delta     (bus.ps2_mouse[15:8]),
        .sign      (bus.ps2_mouse[4]),
        .gain      (bus.gain),
        .add_en    (acc_add),
        .clear     (acc_clear),
        .spring_en (spring_en),
        .acc       (acc_x)
    );

    paddle_axis_accum #(.W(W), .MAX_STEP(MAX_STEP)) u_acc_y (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .delta     (bus.ps2_mouse[23:16]),
        .sign      (bus.ps2_mouse[5]),
        .gain      (bus.gain),
        .add_en    (acc_add),
        .clear     (acc_clear),
        .spring_en (spring_en),
        .acc       (acc_y)
    );

    generate
        if (W >= 8) begin : g_joy_ext
            assign joy_x_map = W'($signed(bus.joya[7:0])) <<< (W - 8);
            assign joy_y_map = W'($signed(bus.joya[15:8])) <<< (W - 8);
        end else begin : g_joy_trunc
            assign joy_x_map = bus.joya[7 -: W];
            assign joy_y_map = bus.joya[15 -: W];
        end
    endgenerate

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            joy_x_q <= '0;
            joy_y_q <= '0;
        end else begin
            joy_x_q <= joy_x_map;
            joy_y_q <= joy_y_map;
        end
    end

    // Both candidates are registers, so the output mux adds no input-to-output path.
    assign axis_x = src_mouse ? acc_x : joy_x_q;
    assign axis_y = src_mouse ? acc_y : joy_y_q;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            prev_x   <= '0;
            prev_y   <= '0;
            prev_src <= 1'b0;
            upd_q    <= 1'b0;
        end else begin
            prev_x   <= axis_x;
            prev_y   <= axis_y;
            prev_src <= src_mouse;
            upd_q    <= (axis_x != prev_x) | (axis_y != prev_y) | (src_mouse != prev_src);
        end
    end

    assign bus.axis_x    = axis_x;
    assign bus.axis_y    = axis_y;
    assign bus.mouse_btn = btn_q;
    assign bus.src_mouse = src_mouse;
    assign bus.upd       = upd_q;

endmodule

// File: tb/tb_paddle_axis_emu.sv
// Directed bench for paddle_axis_emu: a W=8 instance driven from a vector
// table plus hand-written spring/reset sequences, and a W=10 instance in
// joystick-only mode.
module tb_paddle_axis_emu;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic stb8  = 1'b1;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic        tog;
        logic        sx;
        logic [7:0]  dx;
        logic        sy;
        logic [7:0]  dy;
        logic [2:0]  btn;
        logic [15:0] joya;
        logic [1:0]  mode;
        logic [1:0]  gain;
        int          ex;
        int          ey;
        int          esrc;
        int          ebtn;
        int          eupd;
    } vec_t;

    vec_t vecs[$];

    paddle_axis_emu_if #(.W(8))  if8();
    paddle_axis_emu_if #(.W(10)) if10();

    paddle_axis_emu #(.W(8), .MAX_STEP(10), .SPRING_DIV(4)) dut8 (
        .clk_sys (clk),
        .reset   (reset),
        .bus     (if8)
    );

    paddle_axis_emu #(.W(10), .MAX_STEP(10), .SPRING_DIV(4)) dut10 (
        .clk_sys (clk),
        .reset   (reset),
        .bus     (if10)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int tog, input int sx, input int dx, input int sy,
                                input int dy, input int btn, input int joya, input int mode,
                                input int gain, input int ex, input int ey, input int esrc,
                                input int ebtn, input int eupd);
        vec_t v;
        v.tog  = tog[0];
        v.sx   = sx[0];
        v.dx   = dx[7:0];
        v.sy   = sy[0];
        v.dy   = dy[7:0];
        v.btn  = btn[2:0];
        v.joya = joya[15:0];
        v.mode = mode[1:0];
        v.gain = gain[1:0];
        v.ex   = ex;
        v.ey   = ey;
        v.esrc = esrc;
        v.ebtn = ebtn;
        v.eupd = eupd;
        return v;
    endfunction

    task automatic drive8(input vec_t v);
        if (v.tog)
            stb8 = ~stb8;
        if8.ps2_mouse = {stb8, v.dy, v.dx, 2'b00, v.sy, v.sx, 1'b0, v.btn};
        if8.joya      = v.joya;
        if8.mode      = v.mode;
        if8.gain      = v.gain;
    endtask

    task automatic check8(input string tag, input int ex, input int ey, input int esrc,
                          input int ebtn, input int eupd);
        check({tag, ".axis_x"},    int'(if8.axis_x),    ex);
        check({tag, ".axis_y"},    int'(if8.axis_y),    ey);
        check({tag, ".src_mouse"}, int'(if8.src_mouse), esrc);
        check({tag, ".mouse_btn"}, int'(if8.mouse_btn), ebtn);
        check({tag, ".upd"},       int'(if8.upd),       eupd);
    endtask

    initial begin
        vec_t idle3;
        int   ex;

        if8.ps2_mouse  = {1'b1, 24'h0};
        if8.joya       = 16'h0000;
        if8.mode       = 2'd0;
        if8.gain       = 2'd0;
        if10.ps2_mouse = '0;
        if10.joya      = 16'hC040;
        if10.mode      = 2'd1;
        if10.gain      = 2'd0;

        //                tog sx  dx    sy  dy    btn joya     md gn  ex    ey    src btn upd
        vecs.push_back(mk(0,  0, 'h00, 0, 'h00, 0, 'h0000, 0, 0,    0,    0, 0,  0,  0));
        vecs.push_back(mk(1,  0, 'h14, 0, 'h00, 5, 'h0000, 0, 0,   10,    0, 1,  5,  0));
        vecs.push_back(mk(0,  0, 'h14, 0, 'h00, 5, 'h0000, 0, 0,   10,    0, 1,  5,  1));
        vecs.push_back(mk(0,  0, 'h14, 0, 'h00, 5, 'h0000, 0, 0,   10,    0, 1,  5,  0));
        for (int k = 1; k <= 12; k++) begin
            ex = (10 + 10 * k > 127) ? 127 : 10 + 10 * k;
            vecs.push_back(mk(1, 0, 'h14, 0, 'h00, 5, 'h0000, 0, 0, ex, 0, 1, 5, (k == 1) ? 0 : 1));
        end
        vecs.push_back(mk(1,  0, 'h14, 0, 'h00, 5, 'h0000, 0, 0,  127,    0, 1,  5,  1));
        vecs.push_back(mk(0,  0, 'h14, 0, 'h00, 5, 'h0000, 0, 0,  127,    0, 1,  5,  0));
        vecs.push_back(mk(1,  0, 'h00, 1, 'h06, 2, 'h0000, 0, 0,  127,  -10, 1,  2,  0));
        vecs.push_back(mk(1,  1, 'hFF, 0, 'h00, 2, 'h0000, 0, 3,  119,  -10, 1,  2,  1));
        vecs.push_back(mk(1,  1, 'h00, 0, 'h00, 2, 'h0000, 0, 3,  109,  -10, 1,  2,  1));
        vecs.push_back(mk(1,  0, 'h03, 0, 'h03, 2, 'h0000, 0, 1,  111,   -8, 1,  2,  1));
        vecs.push_back(mk(1,  0, 'h14, 0, 'h00, 4, 'h807F, 0, 0,  127, -128, 0,  0,  1));
        vecs.push_back(mk(0,  0, 'h14, 0, 'h00, 4, 'h0000, 0, 0,    0,    0, 0,  0,  1));
        vecs.push_back(mk(1,  0, 'h14, 0, 'h00, 1, 'h0000, 0, 0,   10,    0, 1,  1,  1));
        vecs.push_back(mk(1,  0, 'h14, 0, 'h00, 3, 'h0000, 1, 0,    0,    0, 0,  0,  1));
        vecs.push_back(mk(0,  0, 'h14, 0, 'h00, 3, 'h0000, 2, 0,   10,    0, 1,  0,  1));
        vecs.push_back(mk(1,  1, 'hF2, 0, 'h00, 7, 'h0000, 3, 0,    3,    0, 1,  7,  1));

        repeat (3) @(posedge clk);
        #1;
        check8("reset", 0, 0, 0, 0, 0);
        check("reset.w10_axis_x", int'(if10.axis_x), 0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            drive8(vecs[i]);
            @(posedge clk);
            #1;
            check8($sformatf("v%0d", i), vecs[i].ex, vecs[i].ey, vecs[i].esrc,
                   vecs[i].ebtn, vecs[i].eupd);
        end

        // Spring return from +3 with a 4-cycle period, then hold at 0.
        idle3 = mk(0, 1, 'hF2, 0, 'h00, 7, 'h0000, 3, 0, 0, 0, 1, 7, 0);
        drive8(idle3);
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            ex = (k >= 12) ? 0 : 3 - k / 4;
            check($sformatf("spring%0d.axis_x", k), int'(if8.axis_x), ex);
            check($sformatf("spring%0d.axis_y", k), int'(if8.axis_y), 0);
            check($sformatf("spring%0d.upd", k), int'(if8.upd),
                  (k == 1 || k == 5 || k == 9 || k == 13) ? 1 : 0);
        end

        check("w10.axis_x", int'(if10.axis_x), 256);
        check("w10.axis_y", int'(if10.axis_y), -256);
        check("w10.src_mouse", int'(if10.src_mouse), 0);
        check("w10.mouse_btn", int'(if10.mouse_btn), 0);

        // Reset lands between the strobe toggle and the sampling edge.
        idle3.tog = 1'b1;
        idle3.dx  = 8'h14;
        idle3.sx  = 1'b0;
        drive8(idle3);
        #3;
        reset = 1'b1;
        #1;
        check8("async_rst", 0, 0, 0, 0, 0);
        check("async_rst.w10_axis_x", int'(if10.axis_x), 0);
        check("async_rst.w10_axis_y", int'(if10.axis_y), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst.axis_x", int'(if8.axis_x), 0);
        check("post_rst.axis_y", int'(if8.axis_y), 0);
        check("post_rst.src_mouse", int'(if8.src_mouse), 1);
        check("post_rst.w10_axis_x", int'(if10.axis_x), 256);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
